// File: rtl/spi_cfg_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// spi_cfg_sequencer : walks a register table into the SPI writer and serves
//                     single host writes between walks, with gap/delay/timeout.
// Revision 1.0
// ----------------------------------------------------------------------------
module spi_cfg_sequencer #(
  parameter int TBL_LEN    = 64,
  parameter int AW         = 6,
  parameter int GAP_CYCLES = 16,
  parameter int TIMEOUT    = 1023
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cfg_start,
  output logic [AW-1:0] tbl_addr,
  input  logic [23:0]   tbl_data,
  input  logic          usr_req,
  input  logic [23:0]   usr_data,
  output logic          usr_ack,
  output logic [23:0]   spi_wr_data,
  output logic          spi_wr_valid,
  input  logic          spi_once_end,
  output logic          busy,
  output logic          cfg_done,
  output logic          cfg_err,
  output logic          err_src,
  output logic [AW-1:0] err_idx
);

  localparam logic [AW-1:0] c_last_idx = AW'(TBL_LEN - 1);
  localparam logic [15:0]   c_gap      = 16'(GAP_CYCLES);
  // Completion is still accepted in the TIMEOUT-th cycle after launch.
  localparam logic [15:0]   c_tmo_last = 16'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FETCH    = 3'd1,
    S_DECODE   = 3'd2,
    S_LAUNCH   = 3'd3,
    S_WAIT_END = 3'd4,
    S_GAP      = 3'd5,
    S_DELAY    = 3'd6
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [AW-1:0] r_idx, w_idx_nxt;
  logic          r_mode_usr, w_mode_usr_nxt;
  logic [23:0]   r_wr_data, w_wr_data_nxt;
  logic [15:0]   r_cnt, w_cnt_nxt;
  logic          r_cfg_done, w_cfg_done_nxt;
  logic          r_cfg_err, w_cfg_err_nxt;
  logic          r_err_src, w_err_src_nxt;
  logic [AW-1:0] r_err_idx, w_err_idx_nxt;
  logic          r_usr_ack, w_usr_ack_nxt;
  logic          w_advance;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_mode_usr <= 1'b0;
      r_wr_data  <= '0;
      r_cnt      <= '0;
      r_cfg_done <= 1'b0;
      r_cfg_err  <= 1'b0;
      r_err_src  <= 1'b0;
      r_err_idx  <= '0;
      r_usr_ack  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_idx      <= w_idx_nxt;
      r_mode_usr <= w_mode_usr_nxt;
      r_wr_data  <= w_wr_data_nxt;
      r_cnt      <= w_cnt_nxt;
      r_cfg_done <= w_cfg_done_nxt;
      r_cfg_err  <= w_cfg_err_nxt;
      r_err_src  <= w_err_src_nxt;
      r_err_idx  <= w_err_idx_nxt;
      r_usr_ack  <= w_usr_ack_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_idx_nxt      = r_idx;
    w_mode_usr_nxt = r_mode_usr;
    w_wr_data_nxt  = r_wr_data;
    w_cnt_nxt      = r_cnt;
    w_cfg_done_nxt = r_cfg_done;
    w_cfg_err_nxt  = r_cfg_err;
    w_err_src_nxt  = r_err_src;
    w_err_idx_nxt  = r_err_idx;
    w_usr_ack_nxt  = 1'b0;
    w_advance      = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (cfg_start) begin
          w_idx_nxt      = '0;
          w_mode_usr_nxt = 1'b0;
          w_cfg_done_nxt = 1'b0;
          w_cfg_err_nxt  = 1'b0;
          w_state_nxt    = S_FETCH;
        end else if (usr_req && !r_usr_ack) begin
          // The request level is still high during the ack cycle; don't re-accept it.
          w_mode_usr_nxt = 1'b1;
          w_wr_data_nxt  = usr_data;
          w_state_nxt    = S_LAUNCH;
        end
      end
      S_FETCH:  w_state_nxt = S_DECODE;
      S_DECODE: begin
        if (tbl_data[23]) begin
          w_cnt_nxt   = tbl_data[15:0];
          w_state_nxt = S_DELAY;
        end else begin
          w_wr_data_nxt = tbl_data;
          w_state_nxt   = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        w_cnt_nxt   = '0;
        w_state_nxt = S_WAIT_END;
      end
      S_WAIT_END: begin
        if (spi_once_end) begin
          w_cnt_nxt   = c_gap;
          w_state_nxt = S_GAP;
        end else if (r_cnt == c_tmo_last) begin
          w_cfg_err_nxt = 1'b1;
          w_err_src_nxt = r_mode_usr;
          if (r_mode_usr) w_usr_ack_nxt = 1'b1;
          else            w_err_idx_nxt = r_idx;
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end
      S_GAP, S_DELAY: begin
        if (r_cnt == 16'd0) w_advance = 1'b1;
        else                w_cnt_nxt = r_cnt - 16'd1;
      end
      default: w_state_nxt = S_IDLE;
    endcase

    if (w_advance) begin
      if (r_mode_usr) begin
        w_usr_ack_nxt = 1'b1;
        w_state_nxt   = S_IDLE;
      end else if (r_idx == c_last_idx) begin
        w_cfg_done_nxt = 1'b1;
        w_state_nxt    = S_IDLE;
      end else begin
        w_idx_nxt   = r_idx + 1'b1;
        w_state_nxt = S_FETCH;
      end
    end
  end

  assign tbl_addr     = r_idx;
  assign spi_wr_data  = r_wr_data;
  assign spi_wr_valid = (r_state == S_LAUNCH);
  assign usr_ack      = r_usr_ack;
  assign busy         = (r_state != S_IDLE);
  assign cfg_done     = r_cfg_done;
  assign cfg_err      = r_cfg_err;
  assign err_src      = r_err_src;
  assign err_idx      = r_err_idx;

endmodule
`default_nettype wire

// File: tb/tb_spi_cfg_sequencer.sv
`default_nettype none
// tb_spi_cfg_sequencer: two sequencers (GAP 16 / GAP 0) with table ROM and writer
// models; each monitor pops an ordered queue of expected events with cycle deltas.
module tb_spi_cfg_sequencer;

  localparam int AW      = 2;
  localparam int TBL_LEN = 3;
  localparam int TIMEOUT = 1023;
  localparam int EV_PULSE = 0;
  localparam int EV_ACK   = 1;
  localparam int EV_DONE  = 2;
  localparam int EV_ERR   = 3;

  typedef struct {
    int          side;
    int          kind;
    logic [23:0] data;
    int          dly;
  } ev_t;

  ev_t exp_q[$];
  int  checks   = 0;
  int  failures = 0;
  int  cyc      = 0;
  int  wr_lat   = 50;

  logic        clk       = 1'b0;
  logic        rst_n     = 1'b0;
  logic [1:0]  cfg_start = '0;
  logic [1:0]  usr_req   = '0;
  logic [23:0] usr_data  = '0;
  logic [1:0]  usr_ack, spi_wr_valid, busy, cfg_done, cfg_err, err_src;
  logic [23:0]   spi_wr_data [2];
  logic [AW-1:0] tbl_addr [2];
  logic [AW-1:0] err_idx [2];
  logic [23:0]   tbl_mem [2][4];
  logic [23:0]   hang_data [2];

  always #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  task automatic observe(input int side, input int kind, input logic [23:0] data, input int dly);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL unexpected_event: got side=%0d kind=%0d data=%h dly=%0d, want no event", side, kind, data, dly);
    end else begin
      e = exp_q.pop_front();
      if (e.side != side || e.kind != kind || e.data !== data || (e.dly >= 0 && e.dly != dly)) begin
        failures++;
        $display("FAIL event: got side=%0d kind=%0d data=%h dly=%0d, want side=%0d kind=%0d data=%h dly=%0d",
                 side, kind, data, dly, e.side, e.kind, e.data, e.dly);
      end
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_side
    logic [23:0] rom_q;
    logic        once_end;
    int          wcnt;
    int          last_evt;
    logic        done_q;
    logic        err_q;

    spi_cfg_sequencer #(
      .TBL_LEN(TBL_LEN), .AW(AW), .GAP_CYCLES(g == 0 ? 16 : 0), .TIMEOUT(TIMEOUT)
    ) u_dut (
      .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start[g]), .tbl_addr(tbl_addr[g]),
      .tbl_data(rom_q), .usr_req(usr_req[g]), .usr_data(usr_data), .usr_ack(usr_ack[g]),
      .spi_wr_data(spi_wr_data[g]), .spi_wr_valid(spi_wr_valid[g]), .spi_once_end(once_end),
      .busy(busy[g]), .cfg_done(cfg_done[g]), .cfg_err(cfg_err[g]), .err_src(err_src[g]),
      .err_idx(err_idx[g])
    );

    always @(posedge clk) rom_q <= tbl_mem[g][tbl_addr[g]];

    // Writer: once_end arrives wr_lat cycles after the launch; hang_data never completes.
    always @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                                      wcnt <= 0;
      else if (spi_wr_valid[g] && spi_wr_data[g] != hang_data[g])      wcnt <= wr_lat;
      else if (wcnt != 0)                                              wcnt <= wcnt - 1;
    end
    assign once_end = (wcnt == 1);

    initial begin
      last_evt = 0;
      done_q   = 1'b0;
      err_q    = 1'b0;
      forever begin
        @(negedge clk);
        if (spi_wr_valid[g]) begin
          observe(g, EV_PULSE, spi_wr_data[g], cyc - last_evt); last_evt = cyc;
        end
        if (usr_ack[g]) begin
          observe(g, EV_ACK, 24'd0, cyc - last_evt); last_evt = cyc;
        end
        if (cfg_done[g] && !done_q) begin
          observe(g, EV_DONE, {23'd0, busy[g]}, cyc - last_evt); last_evt = cyc;
        end
        if (cfg_err[g] && !err_q) begin
          observe(g, EV_ERR, {21'd0, err_src[g], err_idx[g]}, cyc - last_evt); last_evt = cyc;
        end
        if (rst_n && !busy[g] && (cfg_start[g] || (usr_req[g] && !usr_ack[g])))
          last_evt = cyc;
        done_q = cfg_done[g];
        err_q  = cfg_err[g];
      end
    end
  end

  task automatic push(input int side, input int kind, input logic [23:0] data, input int dly);
    ev_t e;
    e.side = side; e.kind = kind; e.data = data; e.dly = dly;
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h, want %h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic start(input int side);
    tick(); cfg_start[side] = 1'b1;
    tick(); cfg_start[side] = 1'b0;
  endtask

  task automatic wait_idle(input int side, input int budget, input string name);
    int n = 0;
    while ((exp_q.size() != 0 || busy[side]) && n < budget) begin @(negedge clk); n++; end
    checks++;
    if (n >= budget) begin
      failures++;
      $display("FAIL %s: still busy after %0d cycles, %0d events outstanding, want idle", name, budget, exp_q.size());
    end
  endtask

  task automatic wait_q_empty(input int budget, input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin @(negedge clk); n++; end
    checks++;
    if (n >= budget) begin
      failures++;
      $display("FAIL %s: %0d events outstanding after %0d cycles, want 0", name, exp_q.size(), budget);
    end
  endtask

  task automatic wait_ack(input int side, input int budget);
    int n = 0;
    while (!usr_ack[side] && n < budget) begin @(negedge clk); n++; end
    checks++;
    if (!usr_ack[side]) begin
      failures++;
      $display("FAIL usr_ack_wait: got no ack in %0d cycles, want ack", budget);
    end
    tick(); usr_req[side] = 1'b0;
  endtask

  function automatic logic [63:0] out_vec(input int s);
    return {30'd0, spi_wr_valid[s], usr_ack[s], busy[s], cfg_done[s], cfg_err[s], err_src[s],
            err_idx[s], tbl_addr[s], spi_wr_data[s]};
  endfunction

  task automatic load(input int side, input logic [23:0] a, input logic [23:0] b, input logic [23:0] c);
    tbl_mem[side][0] = a; tbl_mem[side][1] = b; tbl_mem[side][2] = c; tbl_mem[side][3] = 24'd0;
  endtask

  initial begin
    hang_data[0] = 24'hFFFFFF;
    hang_data[1] = 24'hFFFFFF;
    load(0, 24'd0, 24'd0, 24'd0);
    load(1, 24'd0, 24'd0, 24'd0);
    repeat (3) tick();
    check("reset_outputs_a", out_vec(0), 64'd0);
    check("reset_outputs_b", out_vec(1), 64'd0);
    rst_n = 1'b1;

    // Three writes: launch 3 cycles after start, then 50 + 17 gap + fetch/decode/launch = 70.
    load(0, 24'h001234, 24'h00567A, 24'h001F00);
    push(0, EV_PULSE, 24'h001234, 3);
    push(0, EV_PULSE, 24'h00567A, 70);
    push(0, EV_PULSE, 24'h001F00, 70);
    push(0, EV_DONE,  24'h000000, 68);
    start(0);
    wait_idle(0, 2000, "walk3");
    check("walk3_flags", {cfg_done[0], cfg_err[0]}, 64'b10);

    // Delay entry of 100: 70 + 101 delay cycles + fetch/decode = 173, no pulse for it.
    load(0, 24'h001111, 24'h800064, 24'h002222);
    push(0, EV_PULSE, 24'h001111, 3);
    push(0, EV_PULSE, 24'h002222, 173);
    push(0, EV_DONE,  24'h000000, 68);
    start(0);
    wait_idle(0, 2000, "walk_delay");

    // Start and host request together: the walk first, host frame one cycle after it ends.
    load(0, 24'h000A01, 24'h000B02, 24'h000C03);
    push(0, EV_PULSE, 24'h000A01, 3);
    push(0, EV_PULSE, 24'h000B02, 70);
    push(0, EV_PULSE, 24'h000C03, 70);
    push(0, EV_DONE,  24'h000000, 68);
    push(0, EV_PULSE, 24'h003355, 1);
    push(0, EV_ACK,   24'h000000, 68);
    tick(); usr_data = 24'h003355; usr_req[0] = 1'b1; cfg_start[0] = 1'b1;
    tick(); cfg_start[0] = 1'b0;
    wait_ack(0, 2000);
    wait_idle(0, 300, "start_and_user");

    // Entry 1 never completes: error one cycle after the last acceptable completion cycle.
    load(0, 24'h000101, 24'h000202, 24'h000303);
    hang_data[0] = 24'h000202;
    push(0, EV_PULSE, 24'h000101, 3);
    push(0, EV_PULSE, 24'h000202, 70);
    push(0, EV_ERR,   24'h000001, TIMEOUT + 1);
    start(0);
    wait_idle(0, 3000, "hang_walk");
    repeat (100) tick();
    check("hang_flags", {cfg_done[0], cfg_err[0], err_src[0], err_idx[0]}, {59'd0, 1'b0, 1'b1, 1'b0, 2'd1});
    hang_data[0] = 24'hFFFFFF;
    push(0, EV_PULSE, 24'h000101, 3);
    push(0, EV_PULSE, 24'h000202, 70);
    push(0, EV_PULSE, 24'h000303, 70);
    push(0, EV_DONE,  24'h000000, 68);
    start(0);
    check("restart_state", {cfg_err[0], busy[0], tbl_addr[0]}, {60'd0, 1'b0, 1'b1, 2'd0});
    wait_idle(0, 2000, "restart_walk");

    // Reset while waiting on the third entry.
    load(0, 24'h000111, 24'h000222, 24'h000333);
    push(0, EV_PULSE, 24'h000111, 3);
    push(0, EV_PULSE, 24'h000222, 70);
    push(0, EV_PULSE, 24'h000333, 70);
    start(0);
    wait_q_empty(2000, "pre_reset_pulses");
    repeat (10) tick();
    check("in_wait_end", busy[0], 64'd1);
    rst_n = 1'b0;
    #1;
    check("reset_immediate", out_vec(0), 64'd0);
    repeat (2) tick();
    check("reset_held", out_vec(0), 64'd0);
    rst_n = 1'b1;
    repeat (200) tick();
    check("post_reset_quiet", {busy[0], cfg_done[0], cfg_err[0]}, 64'd0);

    // GAP_CYCLES=0 instance with a zero delay entry; cfg_start while busy is ignored.
    load(1, 24'h000A0A, 24'h800000, 24'h000B0B);
    push(1, EV_PULSE, 24'h000A0A, 3);
    push(1, EV_PULSE, 24'h000B0B, 57);
    push(1, EV_DONE,  24'h000000, 52);
    start(1);
    repeat (20) tick();
    cfg_start[1] = 1'b1; tick(); cfg_start[1] = 1'b0;
    wait_idle(1, 1000, "gap0_walk");
    check("gap0_done", cfg_done[1], 64'd1);
    push(1, EV_PULSE, 24'h004444, 1);
    push(1, EV_ACK,   24'h000000, 52);
    tick(); usr_data = 24'h004444; usr_req[1] = 1'b1;
    repeat (10) tick();
    cfg_start[1] = 1'b1; tick(); cfg_start[1] = 1'b0;
    check("busy_start_ignored", {busy[1], cfg_done[1]}, 64'b11);
    wait_ack(1, 500);
    wait_idle(1, 200, "gap0_user");
    check("gap0_done_kept", cfg_done[1], 64'd1);

    repeat (5) tick();
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at time %0t, want finished", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
